// File: rtl/consmax_lut_loader.sv
// consmax_lut_loader
// Streams the two ConSmax exponent lookup tables (LUT0 = low-nibble table,
// LUT1 = high-nibble table) from a valid/ready configuration stream into the
// ConSmax LUT write port. Each accepted word is written one cycle later.
// done pulses alongside the final write. consmax_hold keeps upstream ConSmax
// traffic off the tables while a load or its last write is in flight.
//
// Optional feature: define CONSMAX_LUT_CRC_EN to add a CRC-16-CCITT check
// over the loaded words (cfg_crc in, lut_crc / crc_err out).

module consmax_lut_loader #(
  parameter int IDATA_BIT = 8,
  parameter int EXP_BIT   = 8,
  parameter int MAT_BIT   = 7,
  parameter int LUT_DATA  = EXP_BIT + MAT_BIT + 1,
  parameter int LUT_ADDR  = IDATA_BIT >> 1,
  parameter int LUT_DEPTH = 2 ** LUT_ADDR
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [LUT_DATA-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [LUT_ADDR:0]   lut_waddr,
  output logic                lut_wen,
  output logic [LUT_DATA-1:0] lut_wdata,
  output logic                busy,
  output logic                consmax_hold,
  output logic                done
`ifdef CONSMAX_LUT_CRC_EN
  ,
  input  logic [15:0]         cfg_crc,
  output logic [15:0]         lut_crc,
  output logic                crc_err
`endif
);

  localparam int CNT_W = LUT_ADDR + 1;
  // Index of the final word; the counter stops here instead of wrapping.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(2 * LUT_DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_word;

  assign in_ready     = (state == S_LOAD) && !abort;
  assign accept       = in_valid && in_ready;
  assign last_word    = accept && (cnt == LAST_IDX);
  assign busy         = (state != S_IDLE);
  assign consmax_hold = busy || lut_wen;

  // Next-state selection: start only matters in IDLE, abort always wins.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt; a
    // missing branch in always_comb would otherwise infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_word) state_nxt = S_LAST;
      end
      S_LAST:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Word counter: zero while idle or aborted, advances per accept, parks on
  // the last index so no address beyond the second table is ever produced.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       cnt <= '0;
    else if (state == S_IDLE)        cnt <= '0;
    else if (abort)                  cnt <= '0;
    else if (accept && !last_word)   cnt <= cnt + 1'b1;
  end

  // Registered LUT write port: one write per accept, address/data hold between.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lut_wen   <= 1'b0;
      lut_waddr <= '0;
      lut_wdata <= '0;
    end else begin
      lut_wen <= accept;
      if (accept) begin
        lut_waddr <= cnt;
        lut_wdata <= in_data;
      end
    end
  end

  // done coincides with the final write (the LAST state cycle).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) done <= 1'b0;
    else       done <= last_word;
  end

`ifdef CONSMAX_LUT_CRC_EN
  // CRC-16-CCITT (poly 0x1021), word shifted in MSB first, no reflection.
  function automatic logic [15:0] crc16_word(input logic [15:0]         crc_in,
                                             input logic [LUT_DATA-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = LUT_DATA - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [15:0] crc_nxt;
  assign crc_nxt = crc16_word(lut_crc, in_data);

  // Running CRC, reseeded on an accepted start; mismatch flag latched with done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lut_crc <= 16'hFFFF;
      crc_err <= 1'b0;
    end else if ((state == S_IDLE) && start && !abort) begin
      lut_crc <= 16'hFFFF;
      crc_err <= 1'b0;
    end else if (accept) begin
      lut_crc <= crc_nxt;
      if (last_word) crc_err <= (crc_nxt != cfg_crc);
    end
  end
`endif

endmodule

// File: doc/consmax_lut_loader.md
CONSMAX_LUT_LOADER -- requirements
Module: consmax_lut_loader

Interface
REQ-001 SHALL have parameter IDATA_BIT, default 8, meaning ConSmax INT input width.
REQ-002 SHALL have parameter EXP_BIT, default 8, meaning FP exponent width.
REQ-003 SHALL have parameter MAT_BIT, default 7, meaning FP mantissa width.
REQ-004 SHALL have parameter LUT_DATA, default EXP_BIT+MAT_BIT+1, meaning LUT word width.
REQ-005 SHALL have parameter LUT_ADDR, default IDATA_BIT>>1, meaning per-LUT address width.
REQ-006 SHALL have parameter LUT_DEPTH, default 2**LUT_ADDR, meaning entries per LUT; total load = 2*LUT_DEPTH words.
REQ-007 Ports SHALL be:
  clk  in  1  clock
  rstn  in  1  reset, asynchronous, active-low
  start  in  1  one-cycle request to begin a full table load
  abort  in  1  cancel load in progress
  in_data  in  LUT_DATA  FP table word from config stream
  in_valid  in  1  in_data valid
  in_ready  out  1  loader accepts in_data this cycle
  lut_waddr  out  LUT_ADDR+1  ConSmax LUT write address; MSB selects LUT1
  lut_wen  out  1  ConSmax LUT write enable
  lut_wdata  out  LUT_DATA  ConSmax LUT write data
  busy  out  1  load in progress
  consmax_hold  out  1  upstream SHALL NOT assert ConSmax idata_valid while high
  done  out  1  one-cycle pulse, full table written

Function
REQ-008 FSM states SHALL be IDLE, LOAD, LAST; encoding free.
REQ-009 IDLE: start=1 -> LOAD next cycle, word counter cleared to 0; start in LOAD/LAST SHALL be ignored.
REQ-010 in_ready SHALL be combinational: (state==LOAD) && !abort.
REQ-011 Accept = in_valid && in_ready; each accept SHALL register lut_wen=1, lut_waddr=counter, lut_wdata=in_data for exactly the next cycle (latency 1), then increment counter.
REQ-012 Cycles with no accept SHALL drive lut_wen=0; lut_waddr/lut_wdata SHALL hold last value.
REQ-013 Counter value k SHALL map to lut_waddr=k: words 0..LUT_DEPTH-1 -> LUT0 (low-nibble table), LUT_DEPTH..2*LUT_DEPTH-1 -> LUT1 (high-nibble table).
REQ-014 Accept of word 2*LUT_DEPTH-1 SHALL move LOAD -> LAST; LAST lasts one cycle with lut_wen=1 for that word and done=1, then -> IDLE.
REQ-015 Counter SHALL never wrap; no write to address 2*LUT_DEPTH or above SHALL occur.
REQ-016 abort=1 in LOAD or LAST SHALL force IDLE next cycle, clear counter, suppress done; a write already registered in the abort cycle SHALL still complete; abort+start in IDLE: abort wins, stay IDLE.
REQ-017 busy SHALL be 1 in LOAD and LAST; consmax_hold SHALL equal busy OR lut_wen (covers final write cycle).
REQ-018 in_valid gaps of any length SHALL only stall the load; no timeout.

Reset
REQ-019 rstn low SHALL asynchronously force IDLE, counter 0, lut_wen 0, lut_waddr 0, lut_wdata 0, busy 0, consmax_hold 0, done 0, in_ready 0.
REQ-020 Reset mid-load SHALL discard partial load; no done issued; LUT contents not restored.

Configuration
REQ-021 With CONSMAX_LUT_CRC_EN defined: extra input cfg_crc[15:0] and outputs lut_crc[15:0], crc_err[0]; CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, no reflect/xor-out) SHALL update per accepted word, LUT_DATA bits MSB first; reinit on start; crc_err SHALL register (lut_crc_final != cfg_crc) in the same cycle as done and hold until next start or reset (reset value 0, lut_crc reset 0xFFFF).
REQ-022 Without CONSMAX_LUT_CRC_EN: those ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-023 Default params, start, 32 back-to-back words 0x3F80+k -> lut_wen high 32 cycles, waddr 0..31, wdata 0x3F80..0x3F9F, done pulse on waddr=31 cycle, busy low next cycle.
REQ-024 in_valid toggled 1-0 each cycle -> 32 writes over 63 cycles, lut_wen never high on gap-following cycles, addresses contiguous.
REQ-025 abort after 10 accepts -> 10 writes (waddr 0..9), no done, in_ready 0 in abort cycle; next start rewrites from waddr 0.
REQ-026 start asserted while busy at word 5 -> ignored, counter continues to 31, single done.
REQ-027 rstn low at word 20 -> all outputs reset immediately; fresh start loads 32 words from waddr 0.
REQ-028 CONSMAX_LUT_CRC_EN, all 32 words 0x0000, cfg_crc = correct CRC -> crc_err 0; cfg_crc bit 0 flipped -> crc_err 1 at done.
